// File: rtl/spi_rx_frame_ctrl_if.sv
// Control/status bundle between a burst requester and spi_rx_frame_ctrl.
// The master issues burst requests; the slave (the frame sequencer) reports progress.
interface spi_rx_frame_ctrl_if #(
  parameter int pW_FRAMES = 8
) ();
  logic                 start;
  logic                 abort;
  logic [pW_FRAMES-1:0] frame_num;
  logic                 busy;
  logic [pW_FRAMES-1:0] frame_idx;
  logic                 frame_done;
  logic                 done;
  logic                 last_seen;
  logic                 aborted;
  logic                 err;

  modport master (
    output start, abort, frame_num,
    input  busy, frame_idx, frame_done, done, last_seen, aborted, err
  );

  modport slave (
    input  start, abort, frame_num,
    output busy, frame_idx, frame_done, done, last_seen, aborted, err
  );
endinterface

// File: rtl/spi_rx_frame_ctrl.sv
// Frame sequencer driving the active-low spi_enb window of the 8-lane SPI receiver.
// Optional early stop on the in-band last-word flag: define SPI_RX_LAST_STOP_EN.
module spi_rx_frame_ctrl #(
  parameter int pW_DATA_SPI = 10,
  parameter int pSETUP_CYC  = 1,
  parameter int pGAP_CYC    = 4,
  parameter int pW_FRAMES   = 8
) (
  input  logic               irst,
  input  logic               spi_iclk,
  spi_rx_frame_ctrl_if.slave ctrl,
  input  logic               idata_1,
  output logic               spi_enb
);
  localparam int pMAX_A   = (pW_DATA_SPI > pGAP_CYC) ? pW_DATA_SPI : pGAP_CYC;
  localparam int pCNT_MAX = (pMAX_A > pSETUP_CYC) ? pMAX_A : pSETUP_CYC;
  localparam int pW_CNT   = (pCNT_MAX > 1) ? $clog2(pCNT_MAX) : 1;

  localparam logic [pW_CNT-1:0] pSETUP_LAST = pW_CNT'(pSETUP_CYC - 1);
  localparam logic [pW_CNT-1:0] pSHIFT_LAST = pW_CNT'(pW_DATA_SPI - 1);
  localparam logic [pW_CNT-1:0] pGAP_LAST   = pW_CNT'(pGAP_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t               state_r;
  logic [pW_CNT-1:0]    cnt_r;
  logic [pW_FRAMES-1:0] num_r;
  logic [pW_FRAMES-1:0] frame_idx_r;
  logic                 spi_enb_r;
  logic                 busy_r;
  logic                 frame_done_r;
  logic                 done_r;
  logic                 last_seen_r;
  logic                 aborted_r;
  logic                 err_r;
  logic                 first_bit_flag_s;
  logic                 stop_s;

`ifdef SPI_RX_LAST_STOP_EN
  // The receiver's first shift edge of a frame carries the MSB, i.e. the last-word flag.
  assign first_bit_flag_s = (state_r == ST_SHIFT) && (cnt_r == '0) && idata_1;
  assign stop_s           = last_seen_r;
`else
  logic unused_idata_s;
  assign unused_idata_s   = idata_1;
  assign first_bit_flag_s = 1'b0;
  assign stop_s           = 1'b0;
`endif

  // Burst sequencer: state, counters and all registered outputs.
  always_ff @(posedge spi_iclk or posedge irst) begin
    if (irst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      num_r        <= '0;
      frame_idx_r  <= '0;
      spi_enb_r    <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      done_r       <= 1'b0;
      last_seen_r  <= 1'b0;
      aborted_r    <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      done_r       <= 1'b0;
      aborted_r    <= 1'b0;
      err_r        <= 1'b0;
      if ((state_r != ST_IDLE) && ctrl.abort) begin
        // Partial frame is dropped: frame_idx keeps the completed count.
        state_r   <= ST_IDLE;
        cnt_r     <= '0;
        spi_enb_r <= 1'b1;
        busy_r    <= 1'b0;
        aborted_r <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (ctrl.start && !ctrl.abort) begin
              if (ctrl.frame_num != '0) begin
                state_r     <= ST_SETUP;
                cnt_r       <= '0;
                num_r       <= ctrl.frame_num;
                frame_idx_r <= '0;
                last_seen_r <= 1'b0;
                busy_r      <= 1'b1;
              end else begin
                err_r <= 1'b1;
              end
            end
          end
          ST_SETUP: begin
            if (cnt_r == pSETUP_LAST) begin
              state_r   <= ST_SHIFT;
              cnt_r     <= '0;
              spi_enb_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r + pW_CNT'(1);
            end
          end
          ST_SHIFT: begin
            if (first_bit_flag_s) begin
              last_seen_r <= 1'b1;
            end
            if (cnt_r == pSHIFT_LAST) begin
              state_r      <= ST_GAP;
              cnt_r        <= '0;
              spi_enb_r    <= 1'b1;
              frame_idx_r  <= frame_idx_r + pW_FRAMES'(1);
              frame_done_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + pW_CNT'(1);
            end
          end
          ST_GAP: begin
            if (cnt_r == pGAP_LAST) begin
              cnt_r <= '0;
              if ((frame_idx_r < num_r) && !stop_s) begin
                state_r   <= ST_SHIFT;
                spi_enb_r <= 1'b0;
              end else begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + pW_CNT'(1);
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            spi_enb_r <= 1'b1;
            busy_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi_enb         = spi_enb_r;
  assign ctrl.busy       = busy_r;
  assign ctrl.frame_idx  = frame_idx_r;
  assign ctrl.frame_done = frame_done_r;
  assign ctrl.done       = done_r;
  assign ctrl.last_seen  = last_seen_r;
  assign ctrl.aborted    = aborted_r;
  assign ctrl.err        = err_r;
endmodule

// File: tb/tb_spi_rx_frame_ctrl.sv
// Self-checking bench for spi_rx_frame_ctrl: directed bursts plus randomized bursts
// compared against a timeline model built from frame/gap arithmetic.
module tb_spi_rx_frame_ctrl;
  localparam int W     = 10;
  localparam int SETUP = 1;
  localparam int GAP   = 4;
  localparam int P     = W + GAP;

  logic irst;
  logic clk;
  logic idata_1;
  logic spi_enb;

  int n_cmp;
  int n_err;
  int cur_e;
  int exp_idx_g;
  int exp_last_g;

  spi_rx_frame_ctrl_if #(.pW_FRAMES(8)) ctrl_bus ();

  spi_rx_frame_ctrl #(
    .pW_DATA_SPI(W),
    .pSETUP_CYC (SETUP),
    .pGAP_CYC   (GAP),
    .pW_FRAMES  (8)
  ) dut (
    .irst    (irst),
    .spi_iclk(clk),
    .ctrl    (ctrl_bus.slave),
    .idata_1 (idata_1),
    .spi_enb (spi_enb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_cmp++;
    assert (obs === 32'(expv)) else begin
      n_err++;
      $error("FAIL %s (step %0d): observed %0d expected %0d", tag, cur_e, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with random abort noise: nothing may move.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cur_e = -1;
      ctrl_bus.start = 1'b0;
      ctrl_bus.abort = 1'($urandom_range(0, 1));
      idata_1 = 1'($urandom_range(0, 1));
      tick();
      chk("idle_enb", 32'(spi_enb), 1);
      chk("idle_busy", 32'(ctrl_bus.busy), 0);
      chk("idle_pulses", 32'({ctrl_bus.frame_done, ctrl_bus.done, ctrl_bus.aborted, ctrl_bus.err}), 0);
      chk("idle_idx", 32'(ctrl_bus.frame_idx), exp_idx_g);
      chk("idle_last", 32'(ctrl_bus.last_seen), exp_last_g);
    end
    ctrl_bus.abort = 1'b0;
  endtask

  // lmode: 0 idata low, 1 random idata, 2 flag only on first bit of the third frame.
  task automatic run_burst(input int nf, input int abort_e, input bit spam, input int lmode);
    int nf_eff, n_done, idx_prev, o, done_e, k, r;
    int e_enb, e_busy, e_fd, e_done, e_idx;
    bit ab_hit, ab_any;
    nf_eff = nf; n_done = 0; idx_prev = 0; ab_any = 1'b0; exp_last_g = 0;
    for (int e = 0; e < 5000; e++) begin
      done_e = SETUP + nf_eff * P;
      if (e > done_e + 1) break;
      o = e - SETUP;
      cur_e = e;
      if (e == 0) ctrl_bus.start = 1'b1;
      else if (spam && e <= done_e) ctrl_bus.start = 1'($urandom_range(0, 1));
      else ctrl_bus.start = 1'b0;
      if (e == 0) ctrl_bus.frame_num = 8'(nf);
      else if (spam) ctrl_bus.frame_num = 8'($urandom_range(0, 255));
      ctrl_bus.abort = (e == abort_e) ? 1'b1 : 1'b0;
      case (lmode)
        0: idata_1 = 1'b0;
        1: idata_1 = ($urandom_range(0, 5) == 0);
        default: idata_1 = (o == 2 * P + 1);
      endcase
      ab_hit = (e == abort_e) && (e >= 1) && (e <= done_e);
`ifdef SPI_RX_LAST_STOP_EN
      if (!ab_hit && idata_1 && o >= 1 && ((o - 1) % P) == 0 && ((o - 1) / P) < nf_eff) begin
        nf_eff = (o - 1) / P + 1;
        exp_last_g = 1;
      end
`endif
      tick();
      if (ab_hit) begin
        ab_any = 1'b1;
        chk("abort_enb", 32'(spi_enb), 1);
        chk("abort_busy", 32'(ctrl_bus.busy), 0);
        chk("abort_pulse", 32'(ctrl_bus.aborted), 1);
        chk("abort_no_done", 32'(ctrl_bus.done), 0);
        chk("abort_idx", 32'(ctrl_bus.frame_idx), idx_prev);
        chk("abort_last", 32'(ctrl_bus.last_seen), exp_last_g);
        exp_idx_g = idx_prev;
        break;
      end
      if (o < 0) begin
        e_enb = 1; e_busy = 1; e_fd = 0; e_done = 0; e_idx = 0;
      end else if (o < nf_eff * P) begin
        k = o / P; r = o % P;
        e_enb = (r < W) ? 0 : 1;
        e_fd = (r == W) ? 1 : 0;
        e_idx = k + ((r >= W) ? 1 : 0);
        e_busy = 1; e_done = 0;
      end else begin
        e_enb = 1; e_busy = 0; e_fd = 0;
        e_done = (o == nf_eff * P) ? 1 : 0;
        e_idx = nf_eff;
      end
      chk("spi_enb", 32'(spi_enb), e_enb);
      chk("busy", 32'(ctrl_bus.busy), e_busy);
      chk("frame_done", 32'(ctrl_bus.frame_done), e_fd);
      chk("done", 32'(ctrl_bus.done), e_done);
      chk("frame_idx", 32'(ctrl_bus.frame_idx), e_idx);
      chk("last_seen", 32'(ctrl_bus.last_seen), exp_last_g);
      chk("aborted_quiet", 32'(ctrl_bus.aborted), 0);
      chk("err_quiet", 32'(ctrl_bus.err), 0);
      n_done += int'(ctrl_bus.done);
      idx_prev = e_idx;
      exp_idx_g = e_idx;
    end
    ctrl_bus.start = 1'b0;
    ctrl_bus.abort = 1'b0;
    idata_1 = 1'b0;
    cur_e = -2;
    chk("done_count", 32'(n_done), ab_any ? 0 : 1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cur_e = -1; exp_idx_g = 0; exp_last_g = 0;
    irst = 1'b1; idata_1 = 1'b0;
    ctrl_bus.start = 1'b0; ctrl_bus.abort = 1'b0; ctrl_bus.frame_num = 8'd0;
    #1;
    chk("rst_enb", 32'(spi_enb), 1);
    chk("rst_busy", 32'(ctrl_bus.busy), 0);
    chk("rst_idx", 32'(ctrl_bus.frame_idx), 0);
    chk("rst_last", 32'(ctrl_bus.last_seen), 0);
    chk("rst_pulses", 32'({ctrl_bus.frame_done, ctrl_bus.done, ctrl_bus.aborted, ctrl_bus.err}), 0);
    tick(); tick();
    @(negedge clk) irst = 1'b0;
    idle(50);

    // Three-frame burst with default timing.
    run_burst(3, -1, 1'b0, 0);
    idle(3);

    // Zero-frame request: err only.
    ctrl_bus.start = 1'b1; ctrl_bus.frame_num = 8'd0;
    tick();
    ctrl_bus.start = 1'b0;
    chk("err_pulse", 32'(ctrl_bus.err), 1);
    chk("err_busy", 32'(ctrl_bus.busy), 0);
    chk("err_enb", 32'(spi_enb), 1);
    tick();
    chk("err_one_cycle", 32'(ctrl_bus.err), 0);
    idle(2);

    // Abort during the second frame's shift at bit 4.
    run_burst(5, SETUP + P + 5, 1'b0, 0);
    idle(3);

    // Simultaneous start and abort from IDLE.
    ctrl_bus.start = 1'b1; ctrl_bus.abort = 1'b1; ctrl_bus.frame_num = 8'd3;
    tick();
    ctrl_bus.start = 1'b0; ctrl_bus.abort = 1'b0;
    chk("sa_busy", 32'(ctrl_bus.busy), 0);
    chk("sa_enb", 32'(spi_enb), 1);
    chk("sa_pulses", 32'({ctrl_bus.aborted, ctrl_bus.err}), 0);
    idle(4);

    // Last-word flag at the third frame; full eight frames without the stop option.
    run_burst(8, -1, 1'b0, 2);
    idle(3);

    // Start hammered throughout a two-frame burst.
    run_burst(2, -1, 1'b1, 0);
    idle(3);

    // Randomized bursts with optional abort.
    for (int it = 0; it < 8; it++) begin
      int nf, ab;
      nf = $urandom_range(1, 4);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, SETUP + nf * P) : -1;
      run_burst(nf, ab, 1'($urandom_range(0, 1)), 1);
      idle($urandom_range(1, 5));
    end

    // Asynchronous reset in the middle of a shift window.
    ctrl_bus.start = 1'b1; ctrl_bus.frame_num = 8'd2;
    tick();
    ctrl_bus.start = 1'b0;
    tick(); tick(); tick();
    cur_e = -3;
    chk("mid_shift_enb", 32'(spi_enb), 0);
    #2 irst = 1'b1;
    #1;
    chk("async_rst_enb", 32'(spi_enb), 1);
    chk("async_rst_busy", 32'(ctrl_bus.busy), 0);
    chk("async_rst_idx", 32'(ctrl_bus.frame_idx), 0);
    @(negedge clk) irst = 1'b0;
    exp_idx_g = 0; exp_last_g = 0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_rx_frame_ctrl.md
Name: spi_rx_frame_ctrl

Overview:
Frame sequencer for the 8-lane SPI receive path. It runs in the spi_iclk domain and generates the active-low frame enable spi_enb that gates the receiver's shift registers. Each frame holds spi_enb low for exactly pW_DATA_SPI shift edges, then high for a guard gap so the receiver's system-clock side can capture the word and strobe its output. The block runs a burst of requested frames, supports abort, and can optionally stop early on the in-band last-word flag.

Parameters:
pW_DATA_SPI, 10, bits per frame (shift edges per spi_enb-low window); valid range 2..63
pSETUP_CYC, 1, spi_iclk cycles with spi_enb high between start acceptance and the first frame; minimum 1
pGAP_CYC, 4, spi_iclk cycles with spi_enb high between frames and after the last frame; minimum 2
pW_FRAMES, 8, width of the frame count and frame index

Ports:
irst  in  1  asynchronous reset, active-high
spi_iclk  in  1  SPI bit clock; all logic is on its rising edge
start  in  1  burst request; sampled only in IDLE
abort  in  1  terminates the burst at the next edge
frame_num  in  pW_FRAMES  frames per burst; sampled with start
idata_1  in  1  lane-1 serial data, monitored for the last flag
spi_enb  out  1  frame enable, active-low, registered
busy  out  1  high from start acceptance until done
frame_idx  out  pW_FRAMES  count of completed frames in the current burst
frame_done  out  1  one-cycle pulse at the end of each frame
done  out  1  one-cycle pulse at burst completion
last_seen  out  1  the last flag was seen in the current or most recent burst
aborted  out  1  one-cycle pulse when abort terminates a burst
err  out  1  one-cycle pulse when start is given with frame_num==0

Behaviour:
- Reset values: spi_enb=1; busy, frame_done, done, aborted and err all 0; frame_idx=0; last_seen=0; state=IDLE.
- All outputs are registered.
- States are IDLE, SETUP, SHIFT, GAP.
- IDLE:
  - start=1 and frame_num!=0: latch frame_num; clear frame_idx and last_seen; busy=1; go to SETUP.
  - start=1 and frame_num==0: pulse err; stay in IDLE.
- SETUP: lasts pSETUP_CYC cycles with spi_enb=1, then go to SHIFT.
- SHIFT:
  - spi_enb=0 for exactly pW_DATA_SPI cycles, driven by a bit counter 0..pW_DATA_SPI-1.
  - With pSETUP_CYC=1, start sampled at edge 0 makes spi_enb low after edge 1 and high after edge 1+pW_DATA_SPI.
  - The receiver therefore shifts on edges 2..pW_DATA_SPI+1.
- At the end of SHIFT:
  - spi_enb returns to 1.
  - frame_idx increments (wraps modulo 2^pW_FRAMES; cannot exceed frame_num).
  - frame_done pulses in the first GAP cycle.
- GAP: lasts pGAP_CYC cycles with spi_enb=1.
  - If frame_idx<frame_num and there is no stop condition: go to SHIFT.
  - Otherwise: go to IDLE, pulse done, and drop busy in the same cycle as the done pulse.
- The gap is always applied after the final frame before done, so the receiver completes its capture.
- abort:
  - In any non-IDLE state: spi_enb=1 next cycle, state=IDLE, busy=0, aborted pulses, no done pulse.
  - A partial frame is not counted in frame_idx.
  - In IDLE: ignored.
  - If abort and start are high in the same cycle, abort wins and start is dropped.
- start while busy is ignored; there is no queueing.
- Reset mid-burst: asynchronous return to the reset values, with spi_enb forced to 1 immediately.
- frame_num changes during a burst have no effect.

Optional Feature:
Macro SPI_RX_LAST_STOP_EN.
- Defined:
  - idata_1 is sampled on the first shift edge of each frame; this is the MSB, bit pW_DATA_SPI-1, the last-word flag.
  - If the sample is 1, last_seen is set.
  - The current frame completes normally, followed by its GAP, then done.
  - frame_idx then shows the truncated count.
- Not defined:
  - idata_1 is unused and last_seen is tied to 0.
  - Exactly frame_num frames always run.

Test Plan:
- Reset then idle: spi_enb=1, busy=0, no pulses for 50 cycles; asserting irst mid-SHIFT forces spi_enb=1 asynchronously.
- frame_num=3, defaults, start at edge 0:
  - spi_enb low after edges 1–10, 15–24 and 29–38.
  - frame_done after edges 11, 25 and 39.
  - done after edge 43; frame_idx=3; busy low with done.
- frame_num=0 with start: err pulse one cycle later, busy stays 0, spi_enb stays 1.
- frame_num=5, abort during the 2nd SHIFT at bit 4:
  - spi_enb=1 next cycle, aborted pulses, frame_idx=1, no done.
  - start+abort in the same cycle from IDLE: no burst starts.
- SPI_RX_LAST_STOP_EN, frame_num=8, idata_1=1 at the first bit of frame 3: last_seen=1, 3 frames complete, done after the third GAP, frame_idx=3; without the macro, 8 frames run.
- start pulsed while busy at every cycle of a 2-frame burst: the burst is unaffected and exactly one done pulse occurs.
